prime_sequence_gen: RTL and testbench
=====================================

Name: prime_sequence_gen

Overview:
- Sequential generator that enumerates every prime in [2, 2^WIDTH-1] in ascending order.
- Tests each candidate by trial division, one divisor per cycle.
- Streams each prime out on a valid/ready interface.
- Serves as a golden stimulus/reference source for the combinational prime-detector blocks, and as a standalone prime source.

Parameters:
- WIDTH, 8, bit width of candidates and of out_data; legal range 3..16.

Ports:
- clk  input  1  rising-edge clock; only clock in the block.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request to begin enumeration; sampled only in IDLE or DONE.
- out_ready  input  1  downstream accepts out_data this cycle.
- out_valid  output  1  out_data holds a prime awaiting acceptance.
- out_data  output  WIDTH  current prime.
- busy  output  1  high in TEST or EMIT.
- done  output  1  high in DONE: enumeration finished.
- prime_count  output  WIDTH  number of primes accepted since the last start.

Behaviour:
- Reset (rst=1 at a clk edge, in any state, including mid-test or mid-EMIT):
  - State goes to IDLE; out_valid=0, out_data=0, busy=0, done=0, prime_count=0.
  - Internal cand=0, div=0.
- Registers: cand (WIDTH bits), div (WIDTH bits), prime_count (WIDTH bits), state.
- FSM states: IDLE, TEST, EMIT, DONE.
- IDLE: start=1 -> cand=2, div=2, prime_count=0, go to TEST.
- TEST: exactly one decision per cycle, evaluated in this priority order:
  1. div*div > cand (product computed at 2*WIDTH bits, no overflow) -> cand is prime; go to EMIT.
  2. cand mod div == 0 -> cand is composite; advance candidate (see below).
  3. Otherwise -> div = div+1; stay in TEST.
- Advance candidate: if cand == 2^WIDTH-1, go to DONE. Else cand = cand+1, div = 2, stay in TEST.
  - cand never wraps to 0.
- EMIT:
  - out_valid=1, out_data=cand; both registered, driven from state/cand.
  - Handshake completes on a clk edge with out_valid & out_ready: prime_count increments, then advance candidate.
  - While out_ready=0: out_valid and out_data hold stable indefinitely; no other state changes.
  - out_valid never deasserts without acceptance, except on rst.
- DONE:
  - done=1, out_valid=0, busy=0.
  - out_data and prime_count hold their final values.
  - start=1 restarts exactly as from IDLE (cand=2, prime_count cleared); done drops on the next cycle.
- start in TEST/EMIT is ignored.
- Latency:
  - start sampled at edge N -> TEST at N+1 -> out_valid=1 with out_data=2 after edge N+2.
  - 3 follows 2 cycles after 2 is accepted.
  - Candidate 4 is rejected in one TEST cycle.
- out_data sequence is strictly increasing.
- Total primes emitted fits in WIDTH bits for all legal WIDTH.
- Combinational mod is acceptable; no multicycle divider is required at WIDTH<=16.

Test Plan:
- WIDTH=3, out_ready tied 1, pulse start -> accepted stream exactly 2,3,5,7; prime_count=4; done=1 one cycle after 7 is accepted; set agrees with the 3-bit detector truth table (0,1,4,6 non-prime).
- WIDTH=8, out_ready=1 -> 54 primes; first 2, last 251; prime_count=54; out_valid for 2 first seen 2 cycles after start; every value re-checked by bench modulo model.
- Backpressure, WIDTH=8: hold out_ready=0 for 5 cycles while out_valid=1 at 11 -> out_data stays 11, prime_count unchanged, no skipped or duplicate primes after release.
- Reset mid-run: assert rst while in EMIT with out_data=13 -> next cycle all outputs 0, state IDLE; a new start yields 2 again.
- Start while busy: extra start pulses during TEST/EMIT -> stream unchanged and prime_count not cleared.
- Restart from DONE: after completion, pulse start -> done falls, prime_count clears, stream repeats identically from 2.

Source files
------------

// File: rtl/prime_sequence_gen.sv
// Enumerates every prime in [2, 2^WIDTH-1] in ascending order by trial division,
// one divisor per cycle, and streams each prime out over a valid/ready handshake.
module prime_sequence_gen #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] prime_count
);

  typedef enum logic [1:0] {
    IDLE,
    TEST,
    EMIT,
    DONE
  } state_t;

  localparam logic [WIDTH-1:0] CAND_MAX = '1;
  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
  localparam logic [WIDTH-1:0] TWO      = WIDTH'(2);

  state_t             state;
  logic [WIDTH-1:0]   cand;
  logic [WIDTH-1:0]   div;
  logic [2*WIDTH-1:0] div_sq;
  logic [WIDTH-1:0]   rem;
  logic               div_exceeds;
  logic               is_last;

  // Square at double width so div*div > cand can never be masked by overflow.
  assign div_sq      = {{WIDTH{1'b0}}, div} * {{WIDTH{1'b0}}, div};
  assign div_exceeds = div_sq > {{WIDTH{1'b0}}, cand};
  assign rem         = cand % div;
  assign is_last     = (cand == CAND_MAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cand        <= '0;
      div         <= '0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      prime_count <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state       <= TEST;
            cand        <= TWO;
            div         <= TWO;
            prime_count <= '0;
            busy        <= 1'b1;
            done        <= 1'b0;
          end
        end

        TEST: begin
          if (div_exceeds) begin
            state     <= EMIT;
            out_valid <= 1'b1;
            out_data  <= cand;
          end else if (rem == '0) begin
            if (is_last) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              cand <= cand + ONE;
              div  <= TWO;
            end
          end else begin
            div <= div + ONE;
          end
        end

        EMIT: begin
          // Everything holds until the downstream accepts the prime.
          if (out_ready) begin
            out_valid   <= 1'b0;
            prime_count <= prime_count + ONE;
            if (is_last) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state <= TEST;
              cand  <= cand + ONE;
              div   <= TWO;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_prime_sequence_gen.sv
// Bench for prime_sequence_gen: exact cycle table at WIDTH=3, randomized
// handshake runs at WIDTH=8 scored against a plain primality model.
module tb_prime_sequence_gen;

  logic       clk = 1'b0;
  logic       rst;
  logic       start3, ready3, v3, b3, dn3;
  logic [2:0] data3, cnt3;
  logic       start8, ready8, v8, b8, dn8;
  logic [7:0] data8, cnt8;

  int tests = 0;
  int fails = 0;
  int model8[$];
  int model3[$];
  int got3[$];

  typedef struct {
    bit start;
    bit ready;
    bit valid;
    int data;
    bit busy;
    bit done;
    int count;
  } vec_t;

  vec_t tbl[16];

  always #5 clk = ~clk;

  prime_sequence_gen #(.WIDTH(3)) dut3 (
    .clk(clk), .rst(rst), .start(start3), .out_ready(ready3),
    .out_valid(v3), .out_data(data3), .busy(b3), .done(dn3), .prime_count(cnt3)
  );

  prime_sequence_gen #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .out_ready(ready8),
    .out_valid(v8), .out_data(data8), .busy(b8), .done(dn8), .prime_count(cnt8)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Primality straight from the definition: no divisor in [2, n-1].
  function automatic bit is_prime(input int n);
    if (n < 2) return 1'b0;
    for (int k = 2; k < n; k++)
      if (n % k == 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic run_stream8(input string tag, input bit do_bp, input bit inject_start);
    int         idx = 0;
    int         bp = 0;
    int         cyc = 0;
    logic       pv;
    logic [7:0] pd, pc;
    while (!dn8 && cyc < 20000) begin
      @(negedge clk);
      pv = v8;
      pd = data8;
      pc = cnt8;
      if (do_bp && pv && pd == 8'd11 && bp < 5) begin
        ready8 = 1'b0;
        bp++;
      end else begin
        ready8 = ($urandom_range(0, 3) != 0);
      end
      start8 = inject_start && b8 && ($urandom_range(0, 15) == 0);
      @(posedge clk);
      #1;
      cyc++;
      if (pv && ready8) begin
        chk({tag, " data"}, pd, (idx < model8.size()) ? model8[idx] : 32'hFFFF_FFFF);
        idx++;
        chk({tag, " count"}, cnt8, idx);
        $display("[TB] %s accept #%0d data=%0d count=%0d", tag, idx, pd, cnt8);
      end else if (pv) begin
        chk({tag, " hold valid"}, v8, 1);
        chk({tag, " hold data"}, data8, pd);
        chk({tag, " hold count"}, cnt8, pc);
        if (pd == 8'd11) chk({tag, " bp count at 11"}, cnt8, 4);
      end
    end
    start8 = 1'b0;
    ready8 = 1'b1;
    chk({tag, " finished"}, dn8, 1);
    chk({tag, " total"}, idx, model8.size());
    chk({tag, " final count"}, cnt8, 54);
    chk({tag, " final data"}, data8, 251);
    chk({tag, " done valid"}, v8, 0);
    chk({tag, " done busy"}, b8, 0);
    if (do_bp) chk({tag, " bp cycles"}, bp, 5);
  endtask

  initial begin
    int guard;
    logic pv3;
    logic [2:0] pd3;

    rst = 1'b1;
    start3 = 1'b0; ready3 = 1'b1;
    start8 = 1'b0; ready8 = 1'b1;

    // Expected WIDTH=3 outputs after each edge: start, ready, valid, data, busy, done, count.
    tbl[0]  = '{1, 1, 0, 0, 1, 0, 0};
    tbl[1]  = '{0, 1, 1, 2, 1, 0, 0};
    tbl[2]  = '{0, 1, 0, 2, 1, 0, 1};
    tbl[3]  = '{0, 1, 1, 3, 1, 0, 1};
    tbl[4]  = '{0, 1, 0, 3, 1, 0, 2};
    tbl[5]  = '{0, 1, 0, 3, 1, 0, 2};
    tbl[6]  = '{0, 1, 0, 3, 1, 0, 2};
    tbl[7]  = '{0, 1, 1, 5, 1, 0, 2};
    tbl[8]  = '{0, 1, 0, 5, 1, 0, 3};
    tbl[9]  = '{0, 1, 0, 5, 1, 0, 3};
    tbl[10] = '{0, 1, 0, 5, 1, 0, 3};
    tbl[11] = '{0, 1, 1, 7, 1, 0, 3};
    tbl[12] = '{0, 1, 0, 7, 0, 1, 4};
    tbl[13] = '{0, 1, 0, 7, 0, 1, 4};
    tbl[14] = '{1, 1, 0, 7, 1, 0, 0};
    tbl[15] = '{0, 1, 1, 2, 1, 0, 0};

    for (int n = 0; n < 8; n++)   if (is_prime(n)) model3.push_back(n);
    for (int n = 0; n < 256; n++) if (is_prime(n)) model8.push_back(n);

    repeat (2) @(posedge clk);
    #1;
    chk("rst v3", v3, 0);     chk("rst data3", data3, 0); chk("rst busy3", b3, 0);
    chk("rst done3", dn3, 0); chk("rst cnt3", cnt3, 0);
    chk("rst v8", v8, 0);     chk("rst data8", data8, 0); chk("rst busy8", b8, 0);
    chk("rst done8", dn8, 0); chk("rst cnt8", cnt8, 0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      start3 = tbl[i].start;
      ready3 = tbl[i].ready;
      pv3 = v3;
      pd3 = data3;
      @(posedge clk);
      #1;
      if (pv3 && ready3 && i <= 13) got3.push_back(int'(pd3));
      chk($sformatf("w3[%0d] valid", i), v3, tbl[i].valid);
      chk($sformatf("w3[%0d] data", i), data3, tbl[i].data);
      chk($sformatf("w3[%0d] busy", i), b3, tbl[i].busy);
      chk($sformatf("w3[%0d] done", i), dn3, tbl[i].done);
      chk($sformatf("w3[%0d] count", i), cnt3, tbl[i].count);
    end
    start3 = 1'b0;
    chk("w3 stream size", got3.size(), model3.size());
    for (int i = 0; i < got3.size() && i < model3.size(); i++)
      chk($sformatf("w3 stream[%0d]", i), got3[i], model3[i]);

    // WIDTH=8 run 1: latency, backpressure at 11, spurious starts while busy.
    @(negedge clk); start8 = 1'b1;
    @(posedge clk); #1;
    chk("w8 lat edge1 valid", v8, 0);
    chk("w8 lat edge1 busy", b8, 1);
    @(negedge clk); start8 = 1'b0;
    @(posedge clk); #1;
    chk("w8 lat edge2 valid", v8, 1);
    chk("w8 lat edge2 data", data8, 2);
    run_stream8("run1", 1'b1, 1'b1);

    // Restart from DONE, then reset while 13 is being offered.
    @(negedge clk); start8 = 1'b1;
    @(posedge clk); #1;
    chk("restart done", dn8, 0);
    chk("restart count", cnt8, 0);
    chk("restart busy", b8, 1);
    @(negedge clk); start8 = 1'b0;
    guard = 0;
    while (!(v8 && data8 == 8'd13) && guard < 2000) begin
      @(negedge clk);
      ready8 = 1'b1;
      @(posedge clk); #1;
      guard++;
    end
    chk("reach 13 valid", v8, 1);
    chk("reach 13 data", data8, 13);
    @(negedge clk); rst = 1'b1; ready8 = 1'b0;
    @(posedge clk); #1;
    chk("midrst v8", v8, 0);    chk("midrst data8", data8, 0);
    chk("midrst busy8", b8, 0); chk("midrst done8", dn8, 0);
    chk("midrst cnt8", cnt8, 0);
    @(negedge clk); rst = 1'b0; start8 = 1'b1; ready8 = 1'b1;
    @(posedge clk); #1;
    @(negedge clk); start8 = 1'b0;
    @(posedge clk); #1;
    chk("post rst valid", v8, 1);
    chk("post rst data", data8, 2);
    run_stream8("run2", 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
